// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for the BCD countdown timer.
// The master side drives load/start/pause; the slave (timer) returns the count and flags.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  load_err;

  modport master (
    output load, load_val, start, pause,
    input  q, running, done, load_err
  );

  modport slave (
    input  load, load_val, start, pause,
    output q, running, done, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Packed-BCD countdown timer with prescaled decrement, pause/resume and
// validated preset load. Count, state and all flags are registered.
module bcd_countdown_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  // A one-bit prescaler is kept even when TICK_DIV is 1 so the width never collapses.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    q_r, q_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            running_r;
  logic            done_r, done_nxt;
  logic            load_err_r, load_err_nxt;
  logic            tick;
  logic [W-1:0]    q_dec;

  // True when every nibble holds a legal BCD digit (0..9).
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Subtract one in BCD: zero digits become nine and pass the borrow upward;
  // the first non-zero digit absorbs the borrow.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  assign tick  = (state == RUN) && (presc == TICK_MAX);
  assign q_dec = bcd_dec(q_r);

  // Next-state, next-count and flag logic; load outranks every other control.
  always_comb begin
    state_nxt    = state;
    q_nxt        = q_r;
    presc_nxt    = presc;
    done_nxt     = 1'b0;
    load_err_nxt = load_err_r;

    if (bus.load) begin
      if (bcd_valid(bus.load_val)) begin
        q_nxt        = bus.load_val;
        state_nxt    = IDLE;
        presc_nxt    = '0;
        load_err_nxt = 1'b0;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (q_r != '0)) begin
            state_nxt = RUN;
            presc_nxt = '0;
          end
        end
        RUN: begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          if (tick) q_nxt = q_dec;
          // Reaching zero ends the run even if pause arrives in the same cycle.
          if (tick && (q_dec == '0)) begin
            state_nxt = EXPIRED;
            done_nxt  = 1'b1;
          end else if (bus.pause) begin
            state_nxt = PAUSED;
          end
        end
        PAUSED: begin
          if (bus.start && !bus.pause) state_nxt = RUN;
        end
        EXPIRED: begin
          state_nxt = EXPIRED;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, count, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q_r        <= '0;
      presc      <= '0;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_r        <= q_nxt;
      presc      <= presc_nxt;
      running_r  <= (state_nxt == RUN);
      done_r     <= done_nxt;
      load_err_r <= load_err_nxt;
    end
  end

  assign bus.q        = q_r;
  assign bus.running  = running_r;
  assign bus.done     = done_r;
  assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance with TICK_DIV=1 and
// one with TICK_DIV=4 share a clock and reset.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_countdown_timer_if #(.DIGITS(4)) if1 ();
  bcd_countdown_timer_if #(.DIGITS(4)) if4 ();

  bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer to 4-digit packed BCD by decimal division.
  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic ld, input logic [15:0] v,
                       input logic st, input logic ps);
    if (sel == 0) begin
      if1.load = ld; if1.load_val = v; if1.start = st; if1.pause = ps;
    end else begin
      if4.load = ld; if4.load_val = v; if4.start = st; if4.pause = ps;
    end
  endtask

  task automatic obs(input int sel, output logic [15:0] q, output logic r,
                     output logic d, output logic e);
    if (sel == 0) begin
      q = if1.q; r = if1.running; d = if1.done; e = if1.load_err;
    end else begin
      q = if4.q; r = if4.running; d = if4.done; e = if4.load_err;
    end
  endtask

  // One-cycle command pulse followed by idle inputs.
  task automatic pulse(input int sel, input logic ld, input logic [15:0] v,
                       input logic st, input logic ps);
    drive(sel, ld, v, st, ps);
    step();
    drive(sel, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [15:0] q; logic r, d, e;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      obs(s, q, r, d, e);
      checks++;
      if (q !== 16'h0000 || r !== 1'b0 || d !== 1'b0 || e !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d] q=%h run=%b done=%b err=%b, want 0000 0 0 0", s, q, r, d, e);
      end
    end
  endtask

  task automatic test_full_countdown();
    logic [15:0] q; logic r, d, e;
    int done_cnt;
    done_cnt = 0;
    pulse(0, 1'b1, 16'h0100, 1'b0, 1'b0);
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0100 || r !== 1'b1) begin
      errors++;
      $display("FAIL start_latency q=%h run=%b, want 0100 1", q, r);
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      obs(0, q, r, d, e);
      if (d === 1'b1) done_cnt++;
      checks++;
      if (q !== to_bcd(100 - k) || d !== (k == 100) || r !== (k != 100)) begin
        errors++;
        $display("FAIL countdown_step%0d q=%h done=%b run=%b, want %h %b %b",
                 k, q, d, r, to_bcd(100 - k), (k == 100), (k != 100));
      end
    end
    step();
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0000 || d !== 1'b0 || r !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL after_expire q=%h done=%b run=%b pulses=%0d, want 0000 0 0 1", q, d, r, done_cnt);
    end
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0000 || r !== 1'b0 || d !== 1'b0) begin
      errors++;
      $display("FAIL start_in_expired q=%h run=%b done=%b, want 0000 0 0", q, r, d);
    end
  endtask

  task automatic test_borrow();
    logic [15:0] q; logic r, d, e;
    pulse(0, 1'b1, 16'h1000, 1'b0, 1'b0);
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0999 || r !== 1'b1) begin
      errors++;
      $display("FAIL borrow_chain q=%h run=%b, want 0999 1", q, r);
    end
    pulse(0, 1'b1, 16'h0000, 1'b0, 1'b0);
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0000 || r !== 1'b0) begin
      errors++;
      $display("FAIL load_stops_run q=%h run=%b, want 0000 0", q, r);
    end
  endtask

  task automatic test_pause_resume();
    logic [15:0] q; logic r, d, e;
    logic hold_bad;
    pulse(1, 1'b1, 16'h0005, 1'b0, 1'b0);
    pulse(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    pulse(1, 1'b0, 16'h0000, 1'b0, 1'b1);
    obs(1, q, r, d, e);
    checks++;
    if (q !== 16'h0005 || r !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter q=%h run=%b, want 0005 0", q, r);
    end
    hold_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      obs(1, q, r, d, e);
      if (q !== 16'h0005 || r !== 1'b0) hold_bad = 1'b1;
    end
    checks++;
    if (hold_bad !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold q=%h run=%b, want 0005 0 throughout", q, r);
    end
    pulse(1, 1'b0, 16'h0000, 1'b1, 1'b1);
    obs(1, q, r, d, e);
    checks++;
    if (r !== 1'b0) begin
      errors++;
      $display("FAIL paused_both_high run=%b, want 0", r);
    end
    pulse(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    obs(1, q, r, d, e);
    checks++;
    if (q !== 16'h0005 || r !== 1'b1) begin
      errors++;
      $display("FAIL resume_plus1 q=%h run=%b, want 0005 1", q, r);
    end
    step();
    obs(1, q, r, d, e);
    checks++;
    if (q !== 16'h0004) begin
      errors++;
      $display("FAIL resume_first_dec q=%h, want 0004", q);
    end
    for (int k = 0; k < 4; k++) step();
    obs(1, q, r, d, e);
    checks++;
    if (q !== 16'h0003 || r !== 1'b1) begin
      errors++;
      $display("FAIL resume_period q=%h run=%b, want 0003 1", q, r);
    end
    pulse(1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) step();
    obs(1, q, r, d, e);
    checks++;
    if (q !== 16'h0003 || r !== 1'b0) begin
      errors++;
      $display("FAIL run_start_pause q=%h run=%b, want 0003 0", q, r);
    end
  endtask

  task automatic test_invalid_load();
    logic [15:0] q; logic r, d, e;
    pulse(0, 1'b1, 16'h0042, 1'b0, 1'b0);
    pulse(0, 1'b1, 16'h00A5, 1'b0, 1'b0);
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0042 || e !== 1'b1) begin
      errors++;
      $display("FAIL invalid_load q=%h err=%b, want 0042 1", q, e);
    end
    step();
    step();
    obs(0, q, r, d, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL load_err_sticky err=%b, want 1", e);
    end
    pulse(0, 1'b1, 16'h0010, 1'b0, 1'b0);
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0010 || e !== 1'b0) begin
      errors++;
      $display("FAIL valid_load_clears q=%h err=%b, want 0010 0", q, e);
    end
  endtask

  task automatic test_start_zero();
    logic [15:0] q; logic r, d, e;
    pulse(0, 1'b1, 16'h0000, 1'b0, 1'b0);
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    obs(0, q, r, d, e);
    checks++;
    if (r !== 1'b0 || q !== 16'h0000 || d !== 1'b0) begin
      errors++;
      $display("FAIL start_at_zero run=%b q=%h done=%b, want 0 0000 0", r, q, d);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] q; logic r, d, e;
    pulse(0, 1'b1, 16'h0038, 1'b0, 1'b0);
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step();
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0037 || r !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup q=%h run=%b, want 0037 1", q, r);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs(0, q, r, d, e);
    checks++;
    if (q !== 16'h0000 || r !== 1'b0 || d !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset q=%h run=%b done=%b err=%b, want 0000 0 0 0", q, r, d, e);
    end
    pulse(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    obs(0, q, r, d, e);
    checks++;
    if (r !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_idle run=%b, want 0", r);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0000, 1'b0, 1'b0);
    test_reset();
    test_full_countdown();
    test_borrow();
    test_pause_resume();
    test_invalid_load();
    test_start_zero();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
